mem_access_stage: RTL and testbench

- MEM pipeline stage of the 5-stage core. It sits between the EX/MEM register outputs and the writeback stage.
- Performs sized loads and stores against a variable-latency data memory using a req/ack handshake, and stalls upstream while an access is outstanding.
- Aligns and extends load data, and registers results into the MEM/WB register.
- Flags misaligned accesses and memory timeouts.

---
 rtl/mem_access_stage.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM stage of the 5-stage core. Takes the EX/MEM register contents, performs
// sized loads/stores against a variable-latency data memory over a req/ack
// handshake, aligns/extends load data, and registers results into MEM/WB.
//
// Handshake: a request is open while dm_req=1. The memory completes it by
// raising dm_ack for one cycle, with dm_rdata valid in that same cycle. All
// dm_* request outputs stay stable from the accepting edge until the edge that
// sees dm_ack (or the timeout), after which dm_req drops. Upstream is held via
// stall for as long as a request is open.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_*                EX/MEM register outputs (sampled only when stall=0)
//   stall               upstream must hold EX/MEM contents
//   dm_req/we/addr/be/wdata, dm_ack/rdata   data memory interface
//   wb_valid/regwr/rd/data/exc              MEM/WB register outputs
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_memwr,
  input  logic        in_memtoreg,
  input  logic        in_regwr,
  input  logic        in_ldext,
  input  logic [1:0]  in_dsize,
  input  logic [31:0] in_aluout,
  input  logic [31:0] in_stdata,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_regwr,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exc
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt;

  // Operation fields captured on the accepting edge, used at completion.
  logic        op_load;
  logic        op_regwr;
  logic        op_ldext;
  logic [1:0]  op_dsize;
  logic [4:0]  op_rd;
  logic [31:0] op_addr;

  logic        is_mem, legal, start_access, timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] lane_shift;
  logic [31:0] load_data;

  assign stall = (state == ACCESS);

  always_comb begin
    is_mem = in_memwr | in_memtoreg;
    legal  = 1'b0;
    case (in_dsize)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~in_aluout[0];
      2'b11:   legal = (in_aluout[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
    start_access = (state == IDLE) & in_valid & is_mem & legal;
    // Ack has priority: timeout only counts when no ack is present this cycle.
    timeout_hit  = (state == ACCESS) & ~dm_ack & (cnt == 8'(TIMEOUT - 1));
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = in_stdata;
    case (in_dsize)
      2'b00: begin
        be_next    = 4'b0001 << in_aluout[1:0];
        wdata_next = {4{in_stdata[7:0]}};
      end
      2'b01: begin
        be_next    = in_aluout[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{in_stdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = in_stdata;
      end
    endcase
  end

  // Lane extraction uses the captured address/size since EX/MEM may have
  // moved on by the time the ack arrives in a generic pipeline.
  always_comb begin
    lane_shift = dm_rdata >> {op_addr[1:0], 3'b000};
    load_data  = dm_rdata;
    case (op_dsize)
      2'b00:   load_data = {{24{op_ldext & lane_shift[7]}}, lane_shift[7:0]};
      2'b01: begin
        if (op_addr[1])
          load_data = {{16{op_ldext & dm_rdata[31]}}, dm_rdata[31:16]};
        else
          load_data = {{16{op_ldext & dm_rdata[15]}}, dm_rdata[15:0]};
      end
      default: load_data = dm_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_access) state_next = ACCESS;
      ACCESS:  if (dm_ack || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Request side and captured operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
      cnt      <= '0;
      op_load  <= 1'b0;
      op_regwr <= 1'b0;
      op_ldext <= 1'b0;
      op_dsize <= '0;
      op_rd    <= '0;
      op_addr  <= '0;
    end else if (start_access) begin
      dm_req   <= 1'b1;
      dm_we    <= in_memwr;
      dm_addr  <= {in_aluout[31:2], 2'b00};
      dm_be    <= be_next;
      dm_wdata <= wdata_next;
      cnt      <= '0;
      op_load  <= in_memtoreg & ~in_memwr;
      op_regwr <= in_regwr;
      op_ldext <= in_ldext;
      op_dsize <= in_dsize;
      op_rd    <= in_rd;
      op_addr  <= in_aluout;
    end else if (state == ACCESS) begin
      if (dm_ack || timeout_hit) begin
        dm_req <= 1'b0;
        dm_we  <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_regwr <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_exc   <= 1'b0;
    end else if (state == IDLE) begin
      if (!in_valid || (is_mem && legal)) begin
        // Bubble, or the first cycle of a real memory access.
        wb_valid <= 1'b0;
        wb_regwr <= 1'b0;
      end else begin
        // Non-memory op, or an illegal memory op completing as an exception.
        wb_valid <= 1'b1;
        wb_regwr <= is_mem ? 1'b0 : in_regwr;
        wb_rd    <= in_rd;
        wb_data  <= in_aluout;
        wb_exc   <= is_mem;
      end
    end else begin
      if (dm_ack) begin
        wb_valid <= 1'b1;
        wb_regwr <= op_regwr;
        wb_rd    <= op_rd;
        wb_data  <= op_load ? load_data : op_addr;
        wb_exc   <= 1'b0;
      end else if (timeout_hit) begin
        wb_valid <= 1'b1;
        wb_regwr <= 1'b0;
        wb_rd    <= op_rd;
        wb_data  <= op_addr;
        wb_exc   <= 1'b1;
      end else begin
        wb_valid <= 1'b0;
        wb_regwr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (instantiated with TIMEOUT=4).
module tb_mem_access_stage;

  logic        clk, reset_n;
  logic        in_valid, in_memwr, in_memtoreg, in_regwr, in_ldext;
  logic [1:0]  in_dsize;
  logic [31:0] in_aluout, in_stdata;
  logic [4:0]  in_rd;
  logic        stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        wb_valid, wb_regwr, wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int vectors = 0;
  int errors  = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_memwr(in_memwr), .in_memtoreg(in_memtoreg),
    .in_regwr(in_regwr), .in_ldext(in_ldext), .in_dsize(in_dsize),
    .in_aluout(in_aluout), .in_stdata(in_stdata), .in_rd(in_rd),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_exc(wb_exc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_memwr = 0; in_memtoreg = 0; in_regwr = 0; in_ldext = 0;
    in_dsize = 2'b00; in_aluout = '0; in_stdata = '0; in_rd = '0;
  endtask

  task automatic drive_op(input logic memwr, input logic memtoreg,
                          input logic regwr, input logic ldext,
                          input logic [1:0] dsize, input logic [31:0] addr,
                          input logic [31:0] stdata, input logic [4:0] rd);
    in_valid = 1; in_memwr = memwr; in_memtoreg = memtoreg; in_regwr = regwr;
    in_ldext = ldext; in_dsize = dsize; in_aluout = addr; in_stdata = stdata;
    in_rd = rd;
  endtask

  // Called in the first ACCESS cycle: waits 'waits' cycles, acks, then
  // returns one cycle after the ack edge with inputs idled.
  task automatic finish_access(input int waits, input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) tick();
    dm_ack = 1; dm_rdata = rdata;
    tick();
    dm_ack = 0; dm_rdata = '0;
    idle_in();
  endtask

  task automatic test_reset();
    reset_n = 0; dm_ack = 0; dm_rdata = '0; idle_in();
    #3;
    vectors++; if ({stall, dm_req, dm_we, dm_be, wb_valid, wb_regwr, wb_exc, wb_rd} !== '0) begin errors++; $display("FAIL reset_ctrl: got stall=%b req=%b we=%b be=%b wbv=%b wbr=%b exc=%b rd=%0d, want all 0", stall, dm_req, dm_we, dm_be, wb_valid, wb_regwr, wb_exc, wb_rd); end
    vectors++; if ({dm_addr, dm_wdata, wb_data} !== '0) begin errors++; $display("FAIL reset_data: got addr=%h wdata=%h wbdata=%h, want 0", dm_addr, dm_wdata, wb_data); end
    @(negedge clk); reset_n = 1;
    tick();
    // lw at 0x100, then reset before any ack
    drive_op(0, 1, 1, 0, 2'b11, 32'h100, 0, 5'd3);
    tick();
    vectors++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rst_lw_req: got %b want 1", dm_req); end
    tick();
    reset_n = 0;
    #1;
    vectors++; if (dm_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_mid_access: got req=%b stall=%b want 0 0", dm_req, stall); end
    idle_in(); dm_ack = 1;
    @(negedge clk); reset_n = 1;
    tick();
    vectors++; if (wb_valid !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL stale_ack: got wbv=%b req=%b want 0 0", wb_valid, dm_req); end
    dm_ack = 0;
    tick();
  endtask

  task automatic test_alu();
    drive_op(0, 0, 1, 0, 2'b00, 32'h1234_5678, 32'h0, 5'd5);
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall_pre: got %b want 0", stall); end
    tick();
    idle_in();
    vectors++; if (wb_valid !== 1 || wb_data !== 32'h1234_5678 || wb_rd !== 5'd5 || wb_regwr !== 1 || wb_exc !== 0) begin errors++; $display("FAIL alu_wb: got v=%b d=%h rd=%0d r=%b e=%b want 1 12345678 5 1 0", wb_valid, wb_data, wb_rd, wb_regwr, wb_exc); end
    vectors++; if (stall !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL alu_stall: got stall=%b req=%b want 0 0", stall, dm_req); end
    tick();
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_wbv: got %b want 0", wb_valid); end
  endtask

  task automatic test_store_byte();
    int stall_cycles;
    drive_op(1, 0, 0, 0, 2'b00, 32'h0000_1003, 32'hAABB_CCDD, 5'd0);
    tick();
    vectors++; if (dm_req !== 1 || dm_we !== 1 || dm_addr !== 32'h1000 || dm_be !== 4'b1000 || dm_wdata !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_req: got req=%b we=%b a=%h be=%b wd=%h want 1 1 00001000 1000 dddddddd", dm_req, dm_we, dm_addr, dm_be, dm_wdata); end
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sb_bubble: got %b want 0", wb_valid); end
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (stall) stall_cycles++;
      if (i == 3) dm_ack = 1;
      tick();
    end
    dm_ack = 0; idle_in();
    vectors++; if (stall_cycles != 4 || stall !== 1'b0) begin errors++; $display("FAIL sb_stall: got %0d cycles, now %b, want 4, 0", stall_cycles, stall); end
    vectors++; if (wb_valid !== 1 || wb_regwr !== 0 || wb_exc !== 0 || wb_data !== 32'h1003 || dm_req !== 0) begin errors++; $display("FAIL sb_wb: got v=%b r=%b e=%b d=%h req=%b want 1 0 0 00001003 0", wb_valid, wb_regwr, wb_exc, wb_data, dm_req); end
    tick();
  endtask

  task automatic test_load();
    // lh signed, upper half
    drive_op(0, 1, 1, 1, 2'b01, 32'h2002, 0, 5'd7);
    tick();
    vectors++; if (dm_be !== 4'b1100 || dm_we !== 1'b0 || dm_addr !== 32'h2000) begin errors++; $display("FAIL lh_req: got be=%b we=%b a=%h want 1100 0 00002000", dm_be, dm_we, dm_addr); end
    finish_access(1, 32'h8001_7FFF);
    vectors++; if (wb_data !== 32'hFFFF_8001 || wb_valid !== 1 || wb_regwr !== 1 || wb_rd !== 5'd7 || wb_exc !== 0) begin errors++; $display("FAIL lh_signed: got d=%h v=%b r=%b rd=%0d e=%b want ffff8001 1 1 7 0", wb_data, wb_valid, wb_regwr, wb_rd, wb_exc); end
    tick();
    // lhu
    drive_op(0, 1, 1, 0, 2'b01, 32'h2002, 0, 5'd8);
    tick();
    finish_access(0, 32'h8001_7FFF);
    vectors++; if (wb_data !== 32'h0000_8001) begin errors++; $display("FAIL lh_unsigned: got %h want 00008001", wb_data); end
    tick();
    // lb signed, lane 1
    drive_op(0, 1, 1, 1, 2'b00, 32'h2001, 0, 5'd9);
    tick();
    vectors++; if (dm_be !== 4'b0010) begin errors++; $display("FAIL lb_be: got %b want 0010", dm_be); end
    finish_access(2, 32'h8001_7FFF);
    vectors++; if (wb_data !== 32'h0000_007F || wb_rd !== 5'd9) begin errors++; $display("FAIL lb_signed: got d=%h rd=%0d want 0000007f 9", wb_data, wb_rd); end
    tick();
  endtask

  task automatic test_illegal();
    drive_op(0, 1, 1, 0, 2'b11, 32'h3002, 0, 5'd4);
    tick();
    vectors++; if (dm_req !== 0 || stall !== 0 || wb_valid !== 1 || wb_exc !== 1 || wb_regwr !== 0) begin errors++; $display("FAIL misalign: got req=%b stall=%b v=%b e=%b r=%b want 0 0 1 1 0", dm_req, stall, wb_valid, wb_exc, wb_regwr); end
    drive_op(0, 1, 1, 0, 2'b10, 32'h3000, 0, 5'd4);
    tick();
    idle_in();
    vectors++; if (dm_req !== 0 || stall !== 0 || wb_valid !== 1 || wb_exc !== 1 || wb_regwr !== 0) begin errors++; $display("FAIL rsvd_size: got req=%b stall=%b v=%b e=%b r=%b want 0 0 1 1 0", dm_req, stall, wb_valid, wb_exc, wb_regwr); end
    tick();
    vectors++; if (wb_valid !== 0 || wb_exc !== 1'b0 && wb_valid !== 0) begin errors++; $display("FAIL illegal_after: got v=%b want 0", wb_valid); end
  endtask

  task automatic test_timeout();
    int n;
    drive_op(0, 1, 1, 0, 2'b11, 32'h4000, 0, 5'd9);
    tick();
    n = 0;
    while (dm_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    idle_in();
    vectors++; if (n != 4) begin errors++; $display("FAIL timeout_len: got %0d req cycles want 4", n); end
    vectors++; if (wb_valid !== 1 || wb_exc !== 1 || wb_regwr !== 0 || stall !== 0) begin errors++; $display("FAIL timeout_wb: got v=%b e=%b r=%b stall=%b want 1 1 0 0", wb_valid, wb_exc, wb_regwr, stall); end
    tick();
    // Ack in the 4th cycle beats the timeout
    drive_op(0, 1, 1, 0, 2'b11, 32'h4000, 0, 5'd9);
    tick();
    finish_access(3, 32'hCAFE_BABE);
    vectors++; if (wb_valid !== 1 || wb_exc !== 0 || wb_regwr !== 1 || wb_data !== 32'hCAFE_BABE) begin errors++; $display("FAIL ack_beats_timeout: got v=%b e=%b r=%b d=%h want 1 0 1 cafebabe", wb_valid, wb_exc, wb_regwr, wb_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_byte();
    test_load();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
